// File: rtl/approx_mac_acc.sv
// approx_mac_acc: three-stage signed multiply-accumulate. The low product bits
// can be forced to zero by an approximation mask captured on the first beat of
// each dot product. The accumulator saturates. The block counts beats per dot
// product, and each finished result is held in an output register until the
// consumer accepts it with res_ready_i.
module approx_mac_acc #(
  parameter int IN_WIDTH   = 9,
  parameter int ACC_WIDTH  = 32,
  parameter int N_BIT_APPR = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [IN_WIDTH-1:0]   a_i,
  input  logic [IN_WIDTH-1:0]   b_i,
  input  logic                  last_i,
  input  logic [N_BIT_APPR-1:0] appr_mask_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [ACC_WIDTH-1:0]  res_o,
  output logic                  sat_o,
  output logic [CNT_WIDTH-1:0]  count_o
);
  localparam int PW = 2 * IN_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  if (ACC_WIDTH < PW) begin : g_acc_width_check
    $error("approx_mac_acc: ACC_WIDTH must be >= 2*IN_WIDTH");
  end
  if (N_BIT_APPR > PW) begin : g_mask_width_check
    $error("approx_mac_acc: N_BIT_APPR must be <= 2*IN_WIDTH");
  end

  typedef enum logic {ST_IDLE, ST_ACC} state_e;

  state_e                  state_q, state_d;
  logic [N_BIT_APPR-1:0]   mask_q, mask_d, beat_mask;
  logic                    stall, accept;

  logic                    s1_valid_q, s1_last_q;
  logic signed [IN_WIDTH-1:0] s1_a_q, s1_b_q;
  logic [N_BIT_APPR-1:0]   s1_mask_q;
  logic [PW-1:0]           keep;
  logic signed [PW-1:0]    prod_full, prod_masked;

  logic                    s2_valid_q, s2_last_q;
  logic signed [PW-1:0]    s2_prod_q;

  logic signed [ACC_WIDTH:0]   sum;
  logic signed [ACC_WIDTH-1:0] beat_acc, acc_q, acc_d;
  logic                        beat_sat, sat_q, sat_d;
  logic [CNT_WIDTH-1:0]        beat_cnt, cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]        res_q, res_d;
  logic                        res_sat_q, res_sat_d, res_valid_q, res_valid_d;
  logic [CNT_WIDTH-1:0]        res_cnt_q, res_cnt_d;

  // An unaccepted result freezes the whole pipeline and refuses new beats.
  assign stall   = res_valid_q && !res_ready_i;
  assign ready_o = !stall;
  assign accept  = valid_i && ready_o;

  // Next state and mask capture: the mask of the opening beat holds for the whole dot product.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    mask_d    = mask_q;
    beat_mask = (state_q == ST_IDLE) ? appr_mask_i : mask_q;
    if (accept) begin
      if (state_q == ST_IDLE) mask_d = appr_mask_i;
      state_d = last_i ? ST_IDLE : ST_ACC;
    end
  end

  // State and latched mask registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // S1: capture the accepted operands, the last flag and the effective mask.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mask_q  <= '0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= last_i;
        s1_a_q    <= a_i;
        s1_b_q    <= b_i;
        s1_mask_q <= beat_mask;
      end
    end
  end

  // Exact signed product, then clear low bits whose mask bit is 0. Upper bits always pass through.
  always_comb begin
    keep = '1;
    for (int k = 0; k < N_BIT_APPR; k++) keep[k] = s1_mask_q[k];
    prod_full   = PW'(s1_a_q) * PW'(s1_b_q);
    prod_masked = prod_full & keep;
  end

  // S2: register the masked product.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_prod_q  <= '0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_prod_q  <= prod_masked;
    end
  end

  // S3: saturating accumulate. On a last beat, load the result register and clear the accumulator for the next dot product.
  always_comb begin
    sum      = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(s2_prod_q);
    beat_acc = sum[ACC_WIDTH-1:0];
    beat_sat = sat_q;
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      beat_acc = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      beat_sat = 1'b1;
    end
    beat_cnt = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    acc_d       = acc_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    res_sat_d   = res_sat_q;
    res_cnt_d   = res_cnt_q;
    res_valid_d = res_valid_q && !res_ready_i;
    if (!stall && s2_valid_q) begin
      if (s2_last_q) begin
        res_d       = beat_acc;
        res_sat_d   = beat_sat;
        res_cnt_d   = beat_cnt;
        res_valid_d = 1'b1;
        acc_d       = '0;
        sat_d       = 1'b0;
        cnt_d       = '0;
      end else begin
        acc_d = beat_acc;
        sat_d = beat_sat;
        cnt_d = beat_cnt;
      end
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      res_sat_q   <= 1'b0;
      res_cnt_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      res_sat_q   <= res_sat_d;
      res_cnt_q   <= res_cnt_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;
  assign sat_o       = res_sat_q;
  assign count_o     = res_cnt_q;

endmodule

// File: tb/tb_approx_mac_acc.sv
// Testbench for approx_mac_acc. A transaction-level model turns every accepted
// beat into an expected dot-product result and queues it. A separate monitor
// compares each delivered result against that queue.
module tb_approx_mac_acc;
  localparam int IW = 9;
  localparam int AW = 18;
  localparam int NB = 8;
  localparam int CW = 8;
  localparam longint ACC_MAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (AW - 1));
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic valid_i = 1'b0;
  logic last_i = 1'b0;
  logic res_ready_i = 1'b1;
  logic [IW-1:0] a_i = '0;
  logic [IW-1:0] b_i = '0;
  logic [NB-1:0] appr_mask_i = '0;
  logic ready_o, res_valid_o, sat_o;
  logic [AW-1:0] res_o;
  logic [CW-1:0] count_o;

  always #5 clk = ~clk;

  approx_mac_acc #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .N_BIT_APPR(NB), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .last_i(last_i), .appr_mask_i(appr_mask_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .sat_o(sat_o), .count_o(count_o)
  );

  typedef struct {
    longint res;
    logic   sat;
    int     cnt;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model: the state of the dot product that is currently open.
  bit          m_open;
  logic [NB-1:0] m_mask;
  longint      m_acc;
  bit          m_sat;
  int          m_cnt;

  bit rdy_hold_low = 1'b0;
  bit rdy_rand = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_open = 1'b0;
    m_mask = '0;
    m_acc  = 0;
    m_sat  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_accept(input int a, input int b, input bit last, input logic [NB-1:0] mask);
    longint p;
    logic [2*IW-1:0] pb;
    exp_t e;
    if (!m_open) m_mask = mask;
    p  = longint'(a) * longint'(b);
    pb = p[2*IW-1:0];
    for (int k = 0; k < NB; k++) if (!m_mask[k]) pb[k] = 1'b0;
    p = longint'($signed(pb));
    m_acc = m_acc + p;
    if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_sat = 1'b1; end
    if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_sat = 1'b1; end
    if (m_cnt < CNT_MAX) m_cnt++;
    if (last) begin
      e.res = m_acc; e.sat = m_sat; e.cnt = m_cnt;
      exp_q.push_back(e);
      model_clear();
    end else begin
      m_open = 1'b1;
    end
  endtask

  // Present one beat and keep it on the bus until the DUT takes it.
  task automatic send(input int a, input int b, input bit last, input logic [NB-1:0] mask);
    bit ok = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; a_i = IW'(a); b_i = IW'(b); last_i = last; appr_mask_i = mask;
    for (int t = 0; t < 500 && !ok; t++) begin
      #1;
      if (ready_o) begin
        ok = 1'b1;
        model_accept(a, b, last, mask);
      end
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  // Bubbles carry random data that the DUT must ignore.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_i = 1'b0; a_i = IW'($urandom); b_i = IW'($urandom);
      last_i = 1'($urandom); appr_mask_i = NB'($urandom);
    end
  endtask

  task automatic drain();
    int t;
    @(negedge clk);
    valid_i = 1'b0;
    for (t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic reset_and_check(input int cycles);
    @(negedge clk);
    rst_i = 1'b1; valid_i = 1'b0;
    model_clear();
    exp_q.delete();
    repeat (cycles) @(negedge clk);
    #2;
    check("rst_ready", ready_o, 1);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res", $signed(res_o), 0);
    check("rst_sat", sat_o, 0);
    check("rst_count", count_o, 0);
    rst_i = 1'b0;
  endtask

  // Consumer: always ready, randomly ready, or forced low for a window.
  always @(negedge clk) begin
    if (rdy_hold_low) res_ready_i = 1'b0;
    else if (rdy_rand) res_ready_i = ($urandom_range(0, 2) != 0);
    else res_ready_i = 1'b1;
  end

  // Monitor: score each handoff and confirm that a stalled result holds steady.
  bit hold_prev = 1'b0;
  logic [AW-1:0] prev_res;
  logic prev_sat;
  logic [CW-1:0] prev_cnt;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", res_valid_o, 1);
        check("hold_res", $signed(res_o), $signed(prev_res));
        check("hold_sat", sat_o, prev_sat);
        check("hold_count", count_o, prev_cnt);
      end
      hold_prev = res_valid_o && !res_ready_i;
      prev_res = res_o; prev_sat = sat_o; prev_cnt = count_o;
      if (res_valid_o && res_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("res", $signed(res_o), e.res);
          check("sat", sat_o, e.sat);
          check("count", count_o, e.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len, pick;
    logic [NB-1:0] m;
    model_clear();
    reset_and_check(3);

    // Exact single beat; the result must appear 3 cycles after acceptance.
    send(-3, 5, 1'b1, 8'hFF);
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) valid_i = 1'b0;
      #2;
      if (res_valid_o) break;
    end
    check("latency", n, 3);
    drain();

    // Four-beat dot product with a large last term.
    send(1, 2, 1'b0, 8'hFF);
    send(-4, 3, 1'b0, 8'hFF);
    send(7, 7, 1'b0, 8'hFF);
    send(-256, -256, 1'b1, 8'hFF);
    drain();

    // Approximation: mask taken from the first beat only.
    send(-3, 5, 1'b1, 8'h00);
    send(7, 7, 1'b0, 8'h00);
    send(7, 7, 1'b1, 8'hFF);
    drain();

    // Positive and negative saturation, then a clean dot product right after.
    send(255, 255, 1'b0, 8'hFF);
    send(255, 255, 1'b0, 8'hFF);
    send(255, 255, 1'b1, 8'hFF);
    send(1, 1, 1'b1, 8'hFF);
    send(-256, 255, 1'b0, 8'hFF);
    send(-256, 255, 1'b0, 8'hFF);
    send(-256, 255, 1'b1, 8'hFF);
    drain();

    // Beat counter saturates at its maximum.
    for (int i = 0; i < 260; i++) send(1, 1, (i == 259), 8'hFF);
    drain();

    // Backpressure: the consumer refuses results for a window while beats keep coming.
    rdy_hold_low = 1'b1;
    fork
      begin
        repeat (6) @(negedge clk);
        #2;
        check("bp_ready_low", ready_o, 0);
        check("bp_res_valid", res_valid_o, 1);
        @(negedge clk);
        rdy_hold_low = 1'b0;
      end
      begin
        send(2, 2, 1'b1, 8'hFF);
        send(3, -3, 1'b1, 8'hFF);
        send(10, 11, 1'b0, 8'hFF);
        send(-5, 6, 1'b1, 8'hFF);
        send(100, 100, 1'b1, 8'hFF);
      end
    join
    drain();

    // Random dot products with bubbles, random masks and random result backpressure.
    rdy_rand = 1'b1;
    for (int d = 0; d < 40; d++) begin
      len = int'($urandom_range(1, 6));
      pick = int'($urandom_range(0, 2));
      m = (pick == 0) ? 8'hFF : (pick == 1) ? 8'h00 : NB'($urandom);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
             (j == len - 1), (j == 0) ? m : NB'($urandom));
      end
    end
    drain();
    rdy_rand = 1'b0;

    // Reset in the middle of a dot product discards it; the next beat starts fresh.
    send(9, 9, 1'b0, 8'hFF);
    send(8, 8, 1'b0, 8'hFF);
    reset_and_check(2);
    idle(8);
    send(2, 3, 1'b1, 8'hFF);
    drain();
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
